hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised register scoreboard for the pipeline hazard logic. It replaces the fixed
//  2-source load-use check with per-register pending tracking and variable result latency.
//  Sits between ID and EX: tracks in-flight destinations, stalls ID on RAW/WAW hazards,
//  and flags which sources must take the bypass path instead of the register file.
// PARAMETERS
//  NREGS   32  architectural registers; index 0 is hardwired zero, never pending
//  RP      2   number of source read ports queried per cycle
//  MAX_LAT 7   maximum issue latency (stall cycles before result is bypassable)
//  Derived: RW=$clog2(NREGS), CW=$clog2(MAX_LAT+1)
// PORTS
//  i_clk        in   1        clock, rising edge
//  i_rst        in   1        async reset, active low
//  i_rs_valid   in   RP       source port p is used by instruction in ID
//  i_rs         in   RP*RW    source register indices, port p at [p*RW +: RW]
//  i_issue      in   1        instruction leaves ID into EX this cycle
//  i_issue_we   in   1        issuing instruction writes a register
//  i_issue_rd   in   RW       destination index
//  i_issue_lat  in   CW       cycles until result is bypassable (0 = ALU, 1 = load, ...)
//  i_flush      in   1        branch flush; suppresses this cycle's issue
//  i_wb_valid   in   1        write-back retires a register write
//  i_wb_rd      in   RW       write-back destination index
//  o_stall      out  1        hold IF/ID and insert bubble into ID/EX
//  o_fwd        out  RP       source p must be taken from the bypass network
//  o_stall_cnt  out  32       stall-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  State per reg r: pend[r] (1b) and cnt[r] (CW bits). r=0 is never set.
//  Reset (async, i_rst=0): all pend=0, cnt=0. Outputs: o_stall=0, o_fwd=0, o_stall_cnt=0.
//  Reset mid-operation drops all tracking immediately; no partial state survives.
//  Combinational outputs from current state and inputs (same-cycle, no registers):
//   - RAW(p) = i_rs_valid[p] && rs_p!=0 && pend[rs_p] && cnt[rs_p]!=0
//   - o_fwd[p] = i_rs_valid[p] && rs_p!=0 && pend[rs_p] && cnt[rs_p]==0
//   - WAW = i_issue_we && rd!=0 && pend[rd] && cnt[rd] > i_issue_lat
//   - o_stall = |RAW || WAW
//  Issue accepted at edge when i_issue && !o_stall && !i_flush && i_issue_we && rd!=0.
//  Accepted issue sets pend[rd]=1 and cnt[rd]=i_issue_lat.
//  i_issue while o_stall=1 is a caller error. It is ignored, and SVA flags it.
//  Each edge, every pend reg with cnt!=0 and not newly issued does cnt-=1, saturating at 0.
//  i_wb_valid clears pend[i_wb_rd] at edge.
//  Same-edge issue and wb to the same rd: issue wins (pend=1, cnt=lat).
//  i_issue_lat > MAX_LAT is clamped to MAX_LAT.
//  Latency: issue at edge T with lat L means a dependent source stalls in cycles
//  T..T+L-1 and sees o_fwd=1 from cycle T+L until wb clears pend.
//  No FSM beyond per-register counters; all registers update only on i_clk.
// CONFIGURATION
//  HAZARD_SCOREBOARD_STATS_EN defined:
//   - o_stall_cnt increments by 1 each cycle o_stall=1.
//   - Saturates at 32'hFFFF_FFFF and clears only on reset.
//  Macro undefined: o_stall_cnt tied to 0 and the counter is not synthesised.
// TESTING
//  1 Reset: i_rst=0 for 2 cycles with random inputs -> o_stall=0, o_fwd=0, o_stall_cnt=0.
//  2 ALU back-to-back: issue rd=5 lat=0, next cycle rs0=5 -> o_stall=0, o_fwd[0]=1.
//  3 Load-use: issue rd=7 lat=1, next cycle rs1=7.
//    -> o_stall=1 for one cycle, then o_fwd[1]=1; stats build counts 1.
//  4 x0 and flush: issue rd=0 lat=3, then rs0=0 -> no stall.
//    Issue rd=9 with i_flush=1, then rs0=9 -> no stall, o_fwd=0.
//  5 WAW + wb race: issue rd=3 lat=4, next cycle issue rd=3 lat=0 -> o_stall=1.
//    Wb rd=3 on the same edge as a fresh issue rd=3 -> pend[3] stays 1.
//  6 Saturation (stats build): force counter to 32'hFFFF_FFFE, hold stall 3 cycles
//    -> o_stall_cnt=32'hFFFF_FFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register scoreboard between ID and EX: per-register pending/latency tracking, RAW/WAW stall and bypass select.
// Optional stall statistics counter is built when HAZARD_SCOREBOARD_STATS_EN is defined.
module hazard_scoreboard #(
    parameter int  NREGS   = 32,
    parameter int  RP      = 2,
    parameter int  MAX_LAT = 7,
    localparam int RW      = $clog2(NREGS),
    localparam int CW      = $clog2(MAX_LAT + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [RP-1:0]    i_rs_valid,
    input  logic [RP*RW-1:0] i_rs,
    input  logic             i_issue,
    input  logic             i_issue_we,
    input  logic [RW-1:0]    i_issue_rd,
    input  logic [CW-1:0]    i_issue_lat,
    input  logic             i_flush,
    input  logic             i_wb_valid,
    input  logic [RW-1:0]    i_wb_rd,
    output logic             o_stall,
    output logic [RP-1:0]    o_fwd,
    output logic [31:0]      o_stall_cnt
);
    logic [NREGS-1:0] pend_r;
    logic [CW-1:0]    cnt_r [NREGS];
    logic [RW-1:0]    rs_s [RP];
    logic [RP-1:0]    raw_s;
    logic [RP-1:0]    fwd_s;
    logic             waw_s;
    logic             stall_s;
    logic             accept_s;
    logic [CW-1:0]    lat_s;

    // Clamp requested latency to the deepest supported result latency
    always_comb begin
        if (int'(i_issue_lat) > MAX_LAT) begin
            lat_s = CW'(MAX_LAT);
        end else begin
            lat_s = i_issue_lat;
        end
    end

    // Per-port source lookup: still counting means stall, counted out means bypass
    always_comb begin
        raw_s = {RP{1'b0}};
        fwd_s = {RP{1'b0}};
        for (int p = 0; p < RP; p++) begin
            rs_s[p] = i_rs[p*RW +: RW];
            if (i_rs_valid[p] && (rs_s[p] != {RW{1'b0}}) && pend_r[rs_s[p]]) begin
                raw_s[p] = (cnt_r[rs_s[p]] != {CW{1'b0}});
                fwd_s[p] = (cnt_r[rs_s[p]] == {CW{1'b0}});
            end else begin
                raw_s[p] = 1'b0;
                fwd_s[p] = 1'b0;
            end
        end
    end

    // A younger write must not become bypassable before an older in-flight one
    always_comb begin
        if (i_issue_we && (i_issue_rd != {RW{1'b0}}) && pend_r[i_issue_rd]) begin
            waw_s = (cnt_r[i_issue_rd] > lat_s);
        end else begin
            waw_s = 1'b0;
        end
        stall_s  = (|raw_s) || waw_s;
        accept_s = i_issue && !stall_s && !i_flush && i_issue_we && (i_issue_rd != {RW{1'b0}});
    end

    assign o_stall = stall_s;
    assign o_fwd   = fwd_s;

    // Pending/countdown state; a same-edge issue takes priority over write-back
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pend_r <= {NREGS{1'b0}};
            for (int r = 0; r < NREGS; r++) begin
                cnt_r[r] <= {CW{1'b0}};
            end
        end else begin
            pend_r[0] <= 1'b0;
            cnt_r[0]  <= {CW{1'b0}};
            for (int r = 1; r < NREGS; r++) begin
                if (accept_s && (i_issue_rd == RW'(r))) begin
                    pend_r[r] <= 1'b1;
                    cnt_r[r]  <= lat_s;
                end else begin
                    if (i_wb_valid && (i_wb_rd == RW'(r))) begin
                        pend_r[r] <= 1'b0;
                    end
                    if (pend_r[r] && (cnt_r[r] != {CW{1'b0}})) begin
                        cnt_r[r] <= cnt_r[r] - CW'(1);
                    end
                end
            end
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt_r;

    // Saturating stall-cycle counter, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_r;
`else
    assign o_stall_cnt = 32'd0;
`endif

    hazard_scoreboard_chk u_chk (
        .clk   (i_clk),
        .rst_n (i_rst),
        .issue (i_issue),
        .stall (stall_s),
        .pend0 (pend_r[0])
    );
endmodule

// Protocol checks: no issue attempt while stalled, x0 never pending.
module hazard_scoreboard_chk (
    input logic clk,
    input logic rst_n,
    input logic issue,
    input logic stall,
    input logic pend0
);
    a_no_issue_in_stall: assert property (@(posedge clk) disable iff (!rst_n) !(issue && stall));
    a_x0_never_pending:  assert property (@(posedge clk) disable iff (!rst_n) !pend0);
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised bench for hazard_scoreboard against a ready-time model; honours HAZARD_SCOREBOARD_STATS_EN.
module tb_hazard_scoreboard;
    localparam int NREGS = 32, RP = 2, MAX_LAT = 7, RW = 5, CW = 3;

    logic             i_clk;
    logic             i_rst;
    logic [RP-1:0]    i_rs_valid;
    logic [RP*RW-1:0] i_rs;
    logic             i_issue;
    logic             i_issue_we;
    logic [RW-1:0]    i_issue_rd;
    logic [CW-1:0]    i_issue_lat;
    logic             i_flush;
    logic             i_wb_valid;
    logic [RW-1:0]    i_wb_rd;
    logic             o_stall;
    logic [RP-1:0]    o_fwd;
    logic [31:0]      o_stall_cnt;

    hazard_scoreboard #(.NREGS(NREGS), .RP(RP), .MAX_LAT(MAX_LAT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rs_valid(i_rs_valid), .i_rs(i_rs),
        .i_issue(i_issue), .i_issue_we(i_issue_we), .i_issue_rd(i_issue_rd),
        .i_issue_lat(i_issue_lat), .i_flush(i_flush), .i_wb_valid(i_wb_valid),
        .i_wb_rd(i_wb_rd), .o_stall(o_stall), .o_fwd(o_fwd), .o_stall_cnt(o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Model: each pending register remembers the absolute cycle its result becomes bypassable
    bit     pend_m [NREGS];
    longint ready_m [NREGS];
    longint cyc;
    longint scount;
    int     n_err;
    int     n_chk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rs_of(input int p);
        logic [RW-1:0] r;
        r = i_rs[p*RW +: RW];
        return int'(r);
    endfunction

    function automatic bit m_raw(input int p);
        int r;
        r = rs_of(p);
        return i_rs_valid[p] && (r != 0) && pend_m[r] && (ready_m[r] > cyc);
    endfunction

    function automatic bit m_fwd(input int p);
        int r;
        r = rs_of(p);
        return i_rs_valid[p] && (r != 0) && pend_m[r] && (ready_m[r] <= cyc);
    endfunction

    function automatic int m_lat();
        return (int'(i_issue_lat) > MAX_LAT) ? MAX_LAT : int'(i_issue_lat);
    endfunction

    function automatic bit m_stall();
        int     rd;
        longint remaining;
        bit     waw;
        rd = int'(i_issue_rd);
        remaining = ready_m[rd] - cyc;
        waw = i_issue_we && (rd != 0) && pend_m[rd] && (remaining > longint'(m_lat()));
        return m_raw(0) || m_raw(1) || waw;
    endfunction

    function automatic logic [31:0] m_cnt();
`ifdef HAZARD_SCOREBOARD_STATS_EN
        return scount[31:0];
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            pend_m[r]  = 1'b0;
            ready_m[r] = 0;
        end
        scount = 0;
    endtask

    task automatic model_update();
        bit st;
        bit acc;
        st = m_stall();
        if (st && (scount < 64'h0000_0000_FFFF_FFFF)) scount = scount + 1;
        acc = i_issue && !st && !i_flush && i_issue_we && (i_issue_rd != 5'd0);
        if (i_wb_valid) pend_m[int'(i_wb_rd)] = 1'b0;
        if (acc) begin
            pend_m[int'(i_issue_rd)]  = 1'b1;
            ready_m[int'(i_issue_rd)] = cyc + 1 + longint'(m_lat());
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge i_clk);
        check("stall", {31'd0, o_stall}, {31'd0, m_stall()});
        check("fwd", {30'd0, o_fwd}, {30'd0, m_fwd(1), m_fwd(0)});
        check("stall_cnt", o_stall_cnt, m_cnt());
        @(posedge i_clk);
        model_update();
        #1;
    endtask

    // Issue is only requested when the model says the pipe is not stalled
    task automatic drive(input logic [1:0] v, input int rs0, input int rs1, input logic iss,
                         input logic we, input int rd, input int lat, input logic fl,
                         input logic wbv, input int wbrd);
        i_rs_valid  = v;
        i_rs        = {RW'(rs1), RW'(rs0)};
        i_issue_we  = we;
        i_issue_rd  = RW'(rd);
        i_issue_lat = CW'(lat);
        i_flush     = fl;
        i_wb_valid  = wbv;
        i_wb_rd     = RW'(wbrd);
        i_issue     = 1'b0;
        i_issue     = iss && !m_stall();
    endtask

    task automatic drive_idle();
        drive(2'b00, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        n_err = 0;
        n_chk = 0;
        cyc   = 0;
        model_reset();
        i_rst = 1'b0;
        drive_idle();

        // Reset held two cycles under random inputs
        for (int k = 0; k < 2; k++) begin
            i_rs_valid  = 2'($urandom);
            i_rs        = 10'($urandom);
            i_issue     = 1'($urandom);
            i_issue_we  = 1'($urandom);
            i_issue_rd  = 5'($urandom);
            i_issue_lat = 3'($urandom);
            i_flush     = 1'($urandom);
            i_wb_valid  = 1'($urandom);
            i_wb_rd     = 5'($urandom);
            @(negedge i_clk);
            check("rst_stall", {31'd0, o_stall}, 32'd0);
            check("rst_fwd", {30'd0, o_fwd}, 32'd0);
            check("rst_cnt", o_stall_cnt, 32'd0);
            @(posedge i_clk);
            #1;
        end
        drive_idle();
        i_rst = 1'b1;

        // ALU back-to-back: result bypassable the very next cycle
        drive(2'b00, 0, 0, 1'b1, 1'b1, 5, 0, 1'b0, 1'b0, 0);
        tick();
        drive(2'b01, 5, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        #1;
        check("alu_stall", {31'd0, o_stall}, 32'd0);
        check("alu_fwd", {30'd0, o_fwd}, 32'd1);
        tick();

        // Load-use: one bubble, then bypass on port 1
        drive(2'b00, 0, 0, 1'b1, 1'b1, 7, 1, 1'b0, 1'b0, 0);
        tick();
        drive(2'b10, 0, 7, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        #1;
        check("ld_stall", {31'd0, o_stall}, 32'd1);
        check("ld_fwd0", {30'd0, o_fwd}, 32'd0);
        tick();
        #1;
        check("ld_go", {31'd0, o_stall}, 32'd0);
        check("ld_fwd1", {30'd0, o_fwd}, 32'd2);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        check("ld_cnt", o_stall_cnt, 32'd1);
`endif
        tick();

        // x0 destination and flushed issue never create pending state
        drive(2'b00, 0, 0, 1'b1, 1'b1, 0, 3, 1'b0, 1'b0, 0);
        tick();
        drive(2'b01, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        #1;
        check("x0_stall", {31'd0, o_stall}, 32'd0);
        tick();
        drive(2'b00, 0, 0, 1'b1, 1'b1, 9, 2, 1'b1, 1'b0, 0);
        tick();
        drive(2'b01, 9, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        #1;
        check("flush_stall", {31'd0, o_stall}, 32'd0);
        check("flush_fwd", {30'd0, o_fwd}, 32'd0);
        tick();

        // WAW against a slower in-flight write, then wb/issue race on the same register
        drive(2'b00, 0, 0, 1'b1, 1'b1, 3, 4, 1'b0, 1'b0, 0);
        tick();
        drive(2'b00, 0, 0, 1'b1, 1'b1, 3, 0, 1'b0, 1'b0, 0);
        #1;
        check("waw_stall", {31'd0, o_stall}, 32'd1);
        tick();
        drive(2'b00, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 3);
        tick();
        drive(2'b00, 0, 0, 1'b1, 1'b1, 3, 2, 1'b0, 1'b1, 3);
        tick();
        drive(2'b01, 3, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        #1;
        check("race_pend", {31'd0, o_stall}, 32'd1);
        tick();

`ifdef HAZARD_SCOREBOARD_STATS_EN
        // Counter saturation from just below the ceiling
        drive(2'b00, 0, 0, 1'b1, 1'b1, 12, 7, 1'b0, 1'b0, 0);
        tick();
        force dut.stall_cnt_r = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_r;
        scount = 64'h0000_0000_FFFF_FFFE;
        drive(2'b01, 12, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 3; k++) tick();
        check("sat_cnt", o_stall_cnt, 32'hFFFF_FFFF);
`endif

        // Random traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                i_rst = 1'b0;
                #1;
                check("mid_rst_stall", {31'd0, o_stall}, 32'd0);
                check("mid_rst_fwd", {30'd0, o_fwd}, 32'd0);
                check("mid_rst_cnt", o_stall_cnt, 32'd0);
                model_reset();
                @(posedge i_clk);
                cyc++;
                #1;
                i_rst = 1'b1;
            end
            drive(2'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
